pipeline_scoreboard: RTL
========================

# pipeline_scoreboard

Parametrised hazard-and-forwarding scoreboard for the in-order pipeline; it replaces the separate hazard-detection and forwarding units. It tracks the writeback destination of every instruction issued past ID through `STAGES` post-decode stages, which are EXE, MEM and WB by default. Each cycle it raises a stall for unresolved read-after-write hazards and drives per-operand forwarding selects for the instruction currently in EXE. The load-result availability stage is configurable, and forwarding can be switched on or off at run time.

## Interface
Parameters:
- `REG_ADDR_W`, default 4: register address width.
- `STAGES`, default 3: number of tracked stages after ID. Index 0 is EXE; index `STAGES-1` is the register-file write stage. Minimum value is 2.
- `LOAD_STAGE`, default 2: first stage index at which load data can be forwarded. Legal range is 1..`STAGES-1`.
- `SEL_W`, default `$clog2(STAGES)`: width of each forwarding select.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en_forwarding` in 1: run-time forwarding enable.
- `freeze` in 1: memory not ready. All scoreboard state holds.
- `flush` in 1: branch taken. The instruction in ID is squashed.
- `id_valid` in 1: ID holds a real instruction.
- `id_src1` in `REG_ADDR_W`: first source register of the ID instruction.
- `id_src1_use` in 1: first source is actually read.
- `id_src2` in `REG_ADDR_W`: second source register of the ID instruction.
- `id_src2_use` in 1: second source is actually read (the two-source flag).
- `id_wb_en` in 1: ID instruction writes a register.
- `id_dest` in `REG_ADDR_W`: destination register of the ID instruction.
- `id_mem_read` in 1: ID instruction is a load.
- `stall` out 1: hold IF/ID and insert a bubble.
- `sel_src1` out `SEL_W`: forwarding select for the EXE instruction's first operand. 0 means register-file value; k means the result from stage k.
- `sel_src2` out `SEL_W`: forwarding select for the EXE instruction's second operand, same encoding.
- `stall_count` out 32: saturating stall-cycle counter. Present only with `PIPELINE_SCOREBOARD_PERF_EN`.

## Operation
- State: an array of `STAGES` entries, each holding {valid, wb_en, dest, mem_read}. Separately, EXE source registers {src1, src1_use, src2, src2_use}.
- Shift rule, on each edge where `freeze`=0:
  - entry[k] <= entry[k-1] for k≥1.
  - entry[0] <= the ID instruction if `id_valid` & ~`stall` & ~`flush`; otherwise a bubble (valid=0).
  - The EXE source registers load the ID sources under the same condition; otherwise they clear to use=0.
- A match at stage s on source x means: x_use & entry[s].valid & entry[s].wb_en & entry[s].dest == x.
- Stall with `en_forwarding`=1: any match at stage s where entry[s].mem_read and s < `LOAD_STAGE`-1 (a load whose data would not yet be forwardable).
- Stall with `en_forwarding`=0: any match at stage s in 0..`STAGES`-2. The register file is write-before-read, so the last stage never stalls.
- `stall` is qualified by `id_valid`. It is computed combinationally even while frozen.
- Forwarding selects, computed from the EXE source registers against entries 1..`STAGES`-1:
  - Select the smallest k (youngest producer) that matches.
  - A load entry at k < `LOAD_STAGE` is excluded from selection.
  - If there is no match, or `en_forwarding`=0, the select is 0.
- `flush` and `stall` in the same cycle insert a single bubble, and `stall` still drives.
- Duplicate destinations in flight resolve to the youngest producer.

## Timing
- `stall`, `sel_src1` and `sel_src2` are combinational, available in the same cycle, with no added latency.
- Reset value of every output is 0. On reset all entries become invalid and the EXE source `use` bits clear; this applies even mid-operation, immediately and asynchronously.
- `freeze`=1 holds all state exactly; `sel_*` stays stable for the whole freeze.
- An instruction issued at edge N occupies entry[k] after edge N+k, counting only unfrozen edges.
- Non-load back-to-back dependency with forwarding: 0 stall cycles, and sel=1 in the consumer's EXE cycle.
- Load-use dependency with forwarding: `LOAD_STAGE`-1 stall cycles.
- Any dependency without forwarding: up to `STAGES`-1 stall cycles.

## Configuration
- `PIPELINE_SCOREBOARD_PERF_EN` defined: `stall_count` exists.
  - Reset value 0.
  - Increments by 1 on each edge where `stall`=1 and `freeze`=0.
  - Saturates at 32'hFFFF_FFFF.
- `PIPELINE_SCOREBOARD_PERF_EN` undefined: the port and the counter are absent. Core behaviour is identical.

## Structure
- Shared package holds:
  - the `sb_entry_t` struct {valid, wb_en, dest, mem_read}, parametrised by `REG_ADDR_W` via the package constant;
  - the `SEL_REGFILE`=0 constant.
- One sub-module, `sb_match`: combinational match of one source against one entry, instanced per source per stage.

## Test plan
Default parameters throughout.
- Reset: drive `rst` low mid-stream with entries valid → `stall`=0, `sel_*`=0, `stall_count`=0 immediately; after release, no stall for any sources.
- Forwarding on, ALU dependency: ADD r1 issued, next cycle SUB reads r1 → `stall`=0, then `sel_src1`=1 during SUB's EXE; one cycle later with SUB in MEM, a new reader of r1 gets sel=2.
- Forwarding on, load-use: LDR r2 issued, next cycle ADD reads r2 as src2 → `stall`=1 for exactly 1 cycle, then ADD in EXE with `sel_src2`=2; `stall_count`=1.
- Forwarding off: MOV r3 issued, next cycle consumer reads r3 → `stall`=1 for 2 cycles, then `sel_src1`=0.
- Freeze: after dependency state is established, assert `freeze` for 3 cycles → `sel_*` and `stall` constant, no `stall_count` increments; after release, entries advance one stage per edge.
- Flush: an ID instruction writing r4 is flushed; a next-cycle reader of r4 → `stall`=0 and sel=0; `flush`+`stall` together → exactly one bubble.

Source files
------------

// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scoreboard.
package pipeline_scoreboard_pkg;

  localparam int unsigned SB_REG_ADDR_W = 4;
  localparam int unsigned SB_STAGES     = 3;
  localparam int unsigned SB_LOAD_STAGE = 2;
  localparam int unsigned SB_SEL_W      = $clog2(SB_STAGES);
  localparam int unsigned SEL_REGFILE   = 0;
  localparam int unsigned STALL_COUNT_W = 32;

  // One in-flight instruction's writeback record
  typedef struct packed {
    logic                     valid;
    logic                     wb_en;
    logic [SB_REG_ADDR_W-1:0] dest;
    logic                     mem_read;
  } sb_entry_t;

  // Source operands of the instruction currently in EXE
  typedef struct packed {
    logic [SB_REG_ADDR_W-1:0] src1;
    logic                     src1_use;
    logic [SB_REG_ADDR_W-1:0] src2;
    logic                     src2_use;
  } sb_srcs_t;

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// ID-stage request / hazard-response bundle between the pipeline and the scoreboard.
interface pipeline_scoreboard_if
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = SB_REG_ADDR_W,
  parameter int unsigned SEL_W      = SB_SEL_W
);
  logic                  en_forwarding;
  logic                  freeze;
  logic                  flush;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic                  id_src1_use;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_src2_use;
  logic                  id_wb_en;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_mem_read;
  logic                  stall;
  logic [SEL_W-1:0]      sel_src1;
  logic [SEL_W-1:0]      sel_src2;

  modport master (
    output en_forwarding, freeze, flush, id_valid, id_src1, id_src1_use,
           id_src2, id_src2_use, id_wb_en, id_dest, id_mem_read,
    input  stall, sel_src1, sel_src2
  );

  modport slave (
    input  en_forwarding, freeze, flush, id_valid, id_src1, id_src1_use,
           id_src2, id_src2_use, id_wb_en, id_dest, id_mem_read,
    output stall, sel_src1, sel_src2
  );
endinterface

// File: rtl/sb_match.sv
// Combinational match of one source register against one scoreboard entry.
module sb_match
  import pipeline_scoreboard_pkg::*;
(
  input  logic [SB_REG_ADDR_W-1:0] src_i,
  input  logic                     use_i,
  input  sb_entry_t                entry_i,
  output logic                     match_c_o
);

  assign match_c_o = use_i & entry_i.valid & entry_i.wb_en & (entry_i.dest == src_i);

endmodule

// File: rtl/pipeline_scoreboard.sv
// RAW hazard stall and EXE operand forwarding selects for the in-order pipeline.
// Optional PIPELINE_SCOREBOARD_PERF_EN adds a saturating stall-cycle counter.
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = SB_REG_ADDR_W,
  parameter int unsigned STAGES     = SB_STAGES,
  parameter int unsigned LOAD_STAGE = SB_LOAD_STAGE,
  parameter int unsigned SEL_W      = $clog2(STAGES)
)(
  input  logic                     clk,
  input  logic                     rst,
  pipeline_scoreboard_if.slave     sb
`ifdef PIPELINE_SCOREBOARD_PERF_EN
  ,
  output logic [STALL_COUNT_W-1:0] stall_count
`endif
);

  logic [REG_ADDR_W-1:0] id_src1_w;
  logic [REG_ADDR_W-1:0] id_src2_w;
  logic [REG_ADDR_W-1:0] id_dest_w;

  sb_entry_t             entry_q [STAGES];
  sb_entry_t             entry_d [STAGES];
  sb_srcs_t              exe_q;
  sb_srcs_t              exe_d;

  logic [STAGES-1:0]     id1_hit;
  logic [STAGES-1:0]     id2_hit;
  logic [STAGES-1:1]     ex1_hit;
  logic [STAGES-1:1]     ex2_hit;

  logic                  stall_c;
  logic                  issue_c;
  logic [SEL_W-1:0]      sel1_c;
  logic [SEL_W-1:0]      sel2_c;

  assign id_src1_w = sb.id_src1;
  assign id_src2_w = sb.id_src2;
  assign id_dest_w = sb.id_dest;

  // ID sources are checked against every stage; EXE sources only against older stages
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sb_match u_id1 (
      .src_i     (SB_REG_ADDR_W'(id_src1_w)),
      .use_i     (sb.id_src1_use),
      .entry_i   (entry_q[k]),
      .match_c_o (id1_hit[k])
    );
    sb_match u_id2 (
      .src_i     (SB_REG_ADDR_W'(id_src2_w)),
      .use_i     (sb.id_src2_use),
      .entry_i   (entry_q[k]),
      .match_c_o (id2_hit[k])
    );
    if (k > 0) begin : g_exe
      sb_match u_ex1 (
        .src_i     (exe_q.src1),
        .use_i     (exe_q.src1_use),
        .entry_i   (entry_q[k]),
        .match_c_o (ex1_hit[k])
      );
      sb_match u_ex2 (
        .src_i     (exe_q.src2),
        .use_i     (exe_q.src2_use),
        .entry_i   (entry_q[k]),
        .match_c_o (ex2_hit[k])
      );
    end
  end

  // Stall when a producer's value cannot reach the consumer in time
  always_comb begin
    stall_c = 1'b0;
    for (int s = 0; s < int'(STAGES); s++) begin
      if (id1_hit[s] | id2_hit[s]) begin
        if (sb.en_forwarding) begin
          if (entry_q[s].mem_read && (s < int'(LOAD_STAGE) - 1)) stall_c = 1'b1;
        end else if (s < int'(STAGES) - 1) begin
          stall_c = 1'b1;
        end
      end
    end
    stall_c = stall_c & sb.id_valid;
  end

  // Descending scan so the youngest usable producer wins
  always_comb begin
    sel1_c = SEL_W'(SEL_REGFILE);
    sel2_c = SEL_W'(SEL_REGFILE);
    if (sb.en_forwarding) begin
      for (int k = int'(STAGES) - 1; k >= 1; k--) begin
        if (ex1_hit[k] && !(entry_q[k].mem_read && (k < int'(LOAD_STAGE)))) sel1_c = SEL_W'(k);
        if (ex2_hit[k] && !(entry_q[k].mem_read && (k < int'(LOAD_STAGE)))) sel2_c = SEL_W'(k);
      end
    end
  end

  assign issue_c = sb.id_valid & ~stall_c & ~sb.flush;

  always_comb begin
    entry_d = entry_q;
    exe_d   = exe_q;
    if (!sb.freeze) begin
      for (int k = 1; k < int'(STAGES); k++) entry_d[k] = entry_q[k-1];
      if (issue_c) begin
        entry_d[0] = '{valid: 1'b1, wb_en: sb.id_wb_en,
                       dest: SB_REG_ADDR_W'(id_dest_w), mem_read: sb.id_mem_read};
        exe_d      = '{src1: SB_REG_ADDR_W'(id_src1_w), src1_use: sb.id_src1_use,
                       src2: SB_REG_ADDR_W'(id_src2_w), src2_use: sb.id_src2_use};
      end else begin
        entry_d[0] = '0;
        exe_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(STAGES); k++) entry_q[k] <= '0;
      exe_q <= '0;
    end else begin
      entry_q <= entry_d;
      exe_q   <= exe_d;
    end
  end

  assign sb.stall    = stall_c;
  assign sb.sel_src1 = sel1_c;
  assign sb.sel_src2 = sel2_c;

`ifdef PIPELINE_SCOREBOARD_PERF_EN
  logic [STALL_COUNT_W-1:0] stall_count_q;
  logic [STALL_COUNT_W-1:0] stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_c && !sb.freeze && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_count_q <= '0;
    else      stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule
